// File: rtl/pe_ctrl_seq.sv
// pe_ctrl_seq: job sequencer for a processing element.
// A job produces num_out outputs. Each output is built from num_macc
// enabled accumulate cycles, then one FLUSH cycle and one WRITE cycle.
// A single DONE cycle closes the job. Every output comes straight from a
// flop. The flop value for the next cycle is decoded from the next state.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   start        one-cycle job request, only honoured in IDLE
//   cfg_*        job configuration, captured when start is accepted
//   stall        a high sample at an edge makes the following ACCUM cycle a
//                bubble: enable=0 and no progress
//   ctrl         packed PE control word, MSB->LSB:
//                {norm_fifo_push, norm_fifo_pop, buf_rd_addr, buf_wr_addr,
//                 flush, write_valid, buffer_write_req, buffer_read_req,
//                 enable, op_code}
//   busy         high in every state except IDLE
//   done         one-cycle pulse in the DONE state
module pe_ctrl_seq #(
  parameter int PE_BUF_ADDR_WIDTH = 10,
  parameter int OP_CODE_WIDTH     = 3,
  parameter int CNT_WIDTH         = 8,
  localparam int CTRL_WIDTH       = 2*PE_BUF_ADDR_WIDTH + OP_CODE_WIDTH + 7
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [CNT_WIDTH-1:0]         cfg_num_macc,
  input  logic [CNT_WIDTH-1:0]         cfg_num_out,
  input  logic [OP_CODE_WIDTH-1:0]     cfg_op_code,
  input  logic [PE_BUF_ADDR_WIDTH-1:0] cfg_wr_base,
  input  logic                         cfg_acc_init,
  input  logic                         cfg_norm_en,
  input  logic                         stall,
  output logic [CTRL_WIDTH-1:0]        ctrl,
  output logic                         busy,
  output logic                         done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACCUM = 3'd1,
    S_FLUSH = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                       state_q,    state_d;
  // One bit wider than the count so it can hold num_macc itself.
  logic [CNT_WIDTH:0]           macc_cnt_q, macc_cnt_d;
  logic [CNT_WIDTH-1:0]         out_cnt_q,  out_cnt_d;
  logic [CNT_WIDTH-1:0]         num_macc_q, num_macc_d;
  logic [CNT_WIDTH-1:0]         num_out_q,  num_out_d;
  logic [OP_CODE_WIDTH-1:0]     op_q,       op_d;
  logic [PE_BUF_ADDR_WIDTH-1:0] wr_base_q,  wr_base_d;
  logic                         acc_init_q, acc_init_d;
  logic                         norm_en_q,  norm_en_d;

  // Output flops
  logic                         push_q,     push_d;
  logic                         pop_q,      pop_d;
  logic [PE_BUF_ADDR_WIDTH-1:0] rd_addr_q,  rd_addr_d;
  logic [PE_BUF_ADDR_WIDTH-1:0] wr_addr_q,  wr_addr_d;
  logic                         flush_q,    flush_d;
  logic                         wv_q,       wv_d;
  logic                         wreq_q,     wreq_d;
  logic                         rreq_q,     rreq_d;
  logic                         en_q,       en_d;
  logic [OP_CODE_WIDTH-1:0]     op_out_q,   op_out_d;
  logic                         busy_q,     busy_d;
  logic                         done_q,     done_d;

  logic [CNT_WIDTH:0]           macc_next;
  logic [PE_BUF_ADDR_WIDTH-1:0] out_addr;

  always_comb begin
    state_d    = state_q;
    macc_cnt_d = macc_cnt_q;
    out_cnt_d  = out_cnt_q;
    num_macc_d = num_macc_q;
    num_out_d  = num_out_q;
    op_d       = op_q;
    wr_base_d  = wr_base_q;
    acc_init_d = acc_init_q;
    norm_en_d  = norm_en_q;
    push_d     = 1'b0;
    pop_d      = 1'b0;
    rd_addr_d  = rd_addr_q;
    wr_addr_d  = wr_addr_q;
    flush_d    = 1'b0;
    wv_d       = 1'b0;
    wreq_d     = 1'b0;
    rreq_d     = 1'b0;
    en_d       = 1'b0;
    op_out_d   = '0;
    done_d     = 1'b0;
    busy_d     = 1'b0;

    // MACCs completed once the current cycle ends. A bubble does not count.
    macc_next = macc_cnt_q + {{CNT_WIDTH{1'b0}}, en_q};
    // Address arithmetic wraps modulo the buffer depth.
    out_addr  = wr_base_q + PE_BUF_ADDR_WIDTH'(out_cnt_q);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          num_macc_d = (cfg_num_macc == '0) ? CNT_WIDTH'(1) : cfg_num_macc;
          num_out_d  = (cfg_num_out == '0) ? CNT_WIDTH'(1) : cfg_num_out;
          op_d       = cfg_op_code;
          wr_base_d  = cfg_wr_base;
          acc_init_d = cfg_acc_init;
          norm_en_d  = cfg_norm_en;
          macc_cnt_d = '0;
          out_cnt_d  = '0;
          state_d    = S_ACCUM;
          en_d       = ~stall;
          op_out_d   = cfg_op_code;
        end
      end
      S_ACCUM: begin
        macc_cnt_d = macc_next;
        op_out_d   = op_q;
        // The last MACC is complete, but a stall still holds the FLUSH back.
        if ((macc_next == {1'b0, num_macc_q}) && !stall) begin
          state_d   = S_FLUSH;
          op_out_d  = '0;
          flush_d   = 1'b1;
          rreq_d    = acc_init_q;
          rd_addr_d = out_addr;
        end else begin
          en_d = ~stall;
        end
      end
      S_FLUSH: begin
        state_d   = S_WRITE;
        wv_d      = 1'b1;
        wreq_d    = 1'b1;
        wr_addr_d = out_addr;
        push_d    = norm_en_q;
        // There is nothing to pop before the first output has been pushed.
        pop_d     = norm_en_q && (out_cnt_q != '0);
      end
      S_WRITE: begin
        if (out_cnt_q == num_out_q - CNT_WIDTH'(1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          pop_d   = norm_en_q;
        end else begin
          out_cnt_d  = out_cnt_q + CNT_WIDTH'(1);
          macc_cnt_d = '0;
          state_d    = S_ACCUM;
          en_d       = ~stall;
          op_out_d   = op_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      macc_cnt_q <= '0;
      out_cnt_q  <= '0;
      num_macc_q <= '0;
      num_out_q  <= '0;
      op_q       <= '0;
      wr_base_q  <= '0;
      acc_init_q <= 1'b0;
      norm_en_q  <= 1'b0;
      push_q     <= 1'b0;
      pop_q      <= 1'b0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      flush_q    <= 1'b0;
      wv_q       <= 1'b0;
      wreq_q     <= 1'b0;
      rreq_q     <= 1'b0;
      en_q       <= 1'b0;
      op_out_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      macc_cnt_q <= macc_cnt_d;
      out_cnt_q  <= out_cnt_d;
      num_macc_q <= num_macc_d;
      num_out_q  <= num_out_d;
      op_q       <= op_d;
      wr_base_q  <= wr_base_d;
      acc_init_q <= acc_init_d;
      norm_en_q  <= norm_en_d;
      push_q     <= push_d;
      pop_q      <= pop_d;
      rd_addr_q  <= rd_addr_d;
      wr_addr_q  <= wr_addr_d;
      flush_q    <= flush_d;
      wv_q       <= wv_d;
      wreq_q     <= wreq_d;
      rreq_q     <= rreq_d;
      en_q       <= en_d;
      op_out_q   <= op_out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign ctrl = {push_q, pop_q, rd_addr_q, wr_addr_q, flush_q, wv_q,
                 wreq_q, rreq_q, en_q, op_out_q};
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_pe_ctrl_seq.sv
// tb_pe_ctrl_seq: job-level bench for pe_ctrl_seq.
// Each table record describes one job. The record holds the configuration,
// a per-edge stall mask and the expected job totals. When the job is
// launched, the bench builds the expected per-cycle ctrl/busy/done trace and
// queues it. Each cycle pops one entry and compares it against the DUT. A
// hand-written sequence covers reset arriving in the middle of a job.
`timescale 1ns/1ps
module tb_pe_ctrl_seq;
  localparam int AW  = 10;
  localparam int OW  = 3;
  localparam int CW  = 8;
  localparam int CTW = 2*AW + OW + 7;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [CW-1:0]  cfg_num_macc;
  logic [CW-1:0]  cfg_num_out;
  logic [OW-1:0]  cfg_op_code;
  logic [AW-1:0]  cfg_wr_base;
  logic           cfg_acc_init;
  logic           cfg_norm_en;
  logic           stall;
  logic [CTW-1:0] ctrl;
  logic           busy;
  logic           done;

  always #5 clk = ~clk;

  pe_ctrl_seq #(
    .PE_BUF_ADDR_WIDTH(AW),
    .OP_CODE_WIDTH(OW),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .cfg_num_macc(cfg_num_macc),
    .cfg_num_out(cfg_num_out),
    .cfg_op_code(cfg_op_code),
    .cfg_wr_base(cfg_wr_base),
    .cfg_acc_init(cfg_acc_init),
    .cfg_norm_en(cfg_norm_en),
    .stall(stall),
    .ctrl(ctrl),
    .busy(busy),
    .done(done)
  );

  typedef struct {
    logic [CW-1:0] nm;
    logic [CW-1:0] no;
    logic [OW-1:0] op;
    logic [AW-1:0] base;
    logic          ai;
    logic          ne;
    logic          restart;
    logic [63:0]   smask;
    int            exp_busy;
    int            exp_en;
    int            exp_done;
    int            exp_push;
    int            exp_pop;
    int            exp_rreq;
  } vec_t;

  typedef struct {
    logic [CTW-1:0] ctrl;
    logic           busy;
    logic           done;
  } exp_t;

  exp_t        sb[$];
  vec_t        tbl[7];
  int          checks = 0;
  int          failures = 0;
  logic [AW-1:0] exp_rd = '0;
  logic [AW-1:0] exp_wr = '0;

  function automatic vec_t mk(input int nm, input int no, input int op, input int base,
                              input logic ai, input logic ne, input logic rs,
                              input logic [63:0] sm, input int eb, input int ee,
                              input int ed, input int epu, input int epo, input int err);
    vec_t v;
    v.nm = CW'(nm); v.no = CW'(no); v.op = OW'(op); v.base = AW'(base);
    v.ai = ai; v.ne = ne; v.restart = rs; v.smask = sm;
    v.exp_busy = eb; v.exp_en = ee; v.exp_done = ed;
    v.exp_push = epu; v.exp_pop = epo; v.exp_rreq = err;
    return v;
  endfunction

  function automatic logic [CTW-1:0] pack(input logic push, input logic pop,
                                          input logic [AW-1:0] rd, input logic [AW-1:0] wr,
                                          input logic fl, input logic wv, input logic wq,
                                          input logic rq, input logic en, input logic [OW-1:0] op);
    return {push, pop, rd, wr, fl, wv, wq, rq, en, op};
  endfunction

  function automatic logic sbit(input logic [63:0] m, input int i);
    if (i < 0 || i > 63) return 1'b0;
    return m[i];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Expected trace of a job. Cycle 1 is the cycle after start is sampled.
  // The stall sampled at edge c decides whether cycle c+1 is a bubble.
  task automatic gen_expected(input vec_t v);
    int nm, no, c, dn;
    logic en, fin;
    logic [AW-1:0] a;
    exp_t e;
    nm = (v.nm == 0) ? 1 : int'(v.nm);
    no = (v.no == 0) ? 1 : int'(v.no);
    c  = 1;
    e.busy = 1'b1;
    e.done = 1'b0;
    for (int o = 0; o < no; o++) begin
      a   = v.base + AW'(o);
      dn  = 0;
      fin = 1'b0;
      while (!fin) begin
        en = !sbit(v.smask, c-1);
        e.ctrl = pack(1'b0, 1'b0, exp_rd, exp_wr, 1'b0, 1'b0, 1'b0, 1'b0, en, v.op);
        sb.push_back(e);
        if (en) dn++;
        c++;
        fin = (dn == nm) && !sbit(v.smask, c-1);
      end
      exp_rd = a;
      e.ctrl = pack(1'b0, 1'b0, exp_rd, exp_wr, 1'b1, 1'b0, 1'b0, v.ai, 1'b0, '0);
      sb.push_back(e);
      c++;
      exp_wr = a;
      e.ctrl = pack(v.ne, v.ne && (o != 0), exp_rd, exp_wr, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
      sb.push_back(e);
      c++;
    end
    e.ctrl = pack(1'b0, v.ne, exp_rd, exp_wr, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    e.done = 1'b1;
    sb.push_back(e);
  endtask

  task automatic run_job(input vec_t v, input string tag);
    exp_t e;
    int k = 1;
    int n_busy = 0, n_en = 0, n_push = 0, n_pop = 0, n_rreq = 0, done_at = -1;
    gen_expected(v);
    @(negedge clk);
    cfg_num_macc = v.nm; cfg_num_out = v.no; cfg_op_code = v.op;
    cfg_wr_base = v.base; cfg_acc_init = v.ai; cfg_norm_en = v.ne;
    start = 1'b1;
    stall = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("%s cyc%0d {ctrl,busy,done}", tag, k),
            64'({ctrl, busy, done}), 64'({e.ctrl, e.busy, e.done}));
      n_busy += int'(busy);
      n_en   += int'(ctrl[OW]);
      n_rreq += int'(ctrl[OW+1]);
      n_pop  += int'(ctrl[CTW-2]);
      n_push += int'(ctrl[CTW-1]);
      if (done && done_at < 0) done_at = k;
      stall = sbit(v.smask, k);
      if (v.restart) begin
        start = (k == 2);
        if (k == 2) begin
          cfg_num_macc = 8'd7; cfg_num_out = 8'd5; cfg_op_code = 3'd6;
          cfg_wr_base = 10'd300; cfg_acc_init = 1'b1; cfg_norm_en = 1'b1;
        end
      end
      k++;
      @(negedge clk);
    end
    stall = 1'b0;
    start = 1'b0;
    check({tag, " idle after job {busy,done}"}, 64'({busy, done}), 64'd0);
    check({tag, " busy cycles"}, 64'(n_busy), 64'(v.exp_busy));
    check({tag, " enable cycles"}, 64'(n_en), 64'(v.exp_en));
    check({tag, " done cycle"}, 64'(done_at), 64'(v.exp_done));
    check({tag, " push count"}, 64'(n_push), 64'(v.exp_push));
    check({tag, " pop count"}, 64'(n_pop), 64'(v.exp_pop));
    check({tag, " read_req count"}, 64'(n_rreq), 64'(v.exp_rreq));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            nm no op base  ai    ne    rs    stall   busy en done push pop rreq
    tbl[0] = mk(3, 2, 2, 5,    1'b0, 1'b0, 1'b0, 64'h0, 11, 6, 11, 0, 0, 0);
    tbl[1] = mk(4, 1, 5, 9,    1'b0, 1'b0, 1'b0, 64'hC,  9, 4,  9, 0, 0, 0);
    tbl[2] = mk(1, 2, 7, 1023, 1'b0, 1'b0, 1'b0, 64'h0,  7, 2,  7, 0, 0, 0);
    tbl[3] = mk(2, 3, 1, 100,  1'b1, 1'b1, 1'b0, 64'h0, 13, 6, 13, 3, 3, 3);
    tbl[4] = mk(2, 2, 3, 20,   1'b0, 1'b0, 1'b1, 64'h0,  9, 4,  9, 0, 0, 0);
    tbl[5] = mk(2, 1, 4, 0,    1'b0, 1'b0, 1'b0, 64'h4,  6, 2,  6, 0, 0, 0);
    tbl[6] = mk(0, 0, 6, 500,  1'b1, 1'b1, 1'b0, 64'h0,  4, 1,  4, 1, 1, 1);

    start = 1'b0; stall = 1'b0;
    cfg_num_macc = '0; cfg_num_out = '0; cfg_op_code = '0;
    cfg_wr_base = '0; cfg_acc_init = 1'b0; cfg_norm_en = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    check("reset ctrl", 64'(ctrl), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 6; i++) run_job(tbl[i], $sformatf("job%0d", i));

    // Reset in the middle of the second ACCUM phase of a 3-output job.
    @(negedge clk);
    cfg_num_macc = 8'd3; cfg_num_out = 8'd3; cfg_op_code = 3'd1;
    cfg_wr_base = 10'd40; cfg_acc_init = 1'b1; cfg_norm_en = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("midjob busy/enable before reset", 64'({busy, ctrl[OW]}), 64'b11);
    reset = 1'b0;
    #1;
    check("midjob reset ctrl", 64'(ctrl), 64'd0);
    check("midjob reset {busy,done}", 64'({busy, done}), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    exp_rd = '0;
    exp_wr = '0;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("post-reset quiet cyc%0d {busy,done}", i), 64'({busy, done}), 64'd0);
      @(negedge clk);
    end

    run_job(tbl[6], "job6 after reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
